// File: rtl/calc_core.sv
// calc_core: two-operand add / absolute-difference calculator with a BCD
// seven-segment display output.
//
// Operand A is captured from x on the first debounced button press and
// operand B on the second. The core then computes A+B, or |A-B| when op_sub
// is high, converts the result to BCD with a sequential double-dabble engine
// and shows it on DIGITS registered seven-segment digits.
//
// Parameters:
//   WIDTH            operand width; the result is WIDTH+1 bits
//   DIGITS           number of displayed decimal digits
//   DEBOUNCE_CYCLES  stable cycles required before the debounced level flips
//
// Ports:
//   clk           clock
//   rst           synchronous active-high reset
//   button        raw push-button, active-high, asynchronous to clk
//   x             operand switches, unsigned
//   op_sub        0 = add, 1 = subtract; sampled together with operand B
//   seg           seg[7k+6:7k] drives digit k (k=0 least significant),
//                 bit 0 = segment a ... bit 6 = segment g, active-high
//   neg           the last subtraction had A < B
//   busy          high while the BCD conversion runs
//   result_valid  one-cycle pulse when seg/neg first show a new result
//
// Build option:
//   CALC_LEADING_ZERO_BLANK_EN  when defined, leading zero digits above digit 0
//                               are blanked instead of showing "0".
module calc_core #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DIGITS          = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  button,
  input  logic [WIDTH-1:0]      x,
  input  logic                  op_sub,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  neg,
  output logic                  busy,
  output logic                  result_valid
);

  localparam int unsigned RW    = WIDTH + 1;
  localparam int unsigned BcdW  = 4 * DIGITS;
  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned StepW = $clog2(RW + 1);

  function automatic bit digits_fit();
    longint unsigned p = 1;
    for (int unsigned i = 0; i < DIGITS; i++) p = p * 10;
    return p > ((64'd1 << RW) - 64'd2);
  endfunction

  if (!digits_fit()) begin : gen_digits_check
    $error("calc_core: DIGITS too small for the largest result");
  end
  if (DEBOUNCE_CYCLES < 1) begin : gen_debounce_check
    $error("calc_core: DEBOUNCE_CYCLES must be at least 1");
  end

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b0111111;
      4'd1:    seg7 = 7'b0000110;
      4'd2:    seg7 = 7'b1011011;
      4'd3:    seg7 = 7'b1001111;
      4'd4:    seg7 = 7'b1100110;
      4'd5:    seg7 = 7'b1101101;
      4'd6:    seg7 = 7'b1111101;
      4'd7:    seg7 = 7'b0000111;
      4'd8:    seg7 = 7'b1111111;
      4'd9:    seg7 = 7'b1101111;
      default: seg7 = 7'b0000000;
    endcase
  endfunction

  // Button synchroniser and debouncer
  logic            meta_q, sync_q, level_q, level_prev_q;
  logic [CntW-1:0] cnt_q;
  logic            press_evt;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q       <= 1'b0;
      sync_q       <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      meta_q       <= button;
      sync_q       <= meta_q;
      level_prev_q <= level_q;
      if (sync_q != level_q) begin
        if (cnt_q == CntW'(DEBOUNCE_CYCLES - 1)) begin
          level_q <= ~level_q;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  // Rising edge of the debounced level only; release is silent.
  assign press_evt = level_q & ~level_prev_q;

  // Calculator FSM and double-dabble datapath
  typedef enum logic [1:0] {StCapA, StCapB, StConvert, StShow} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    a_q, a_d;
  logic [RW-1:0]       bin_q, bin_d, bin_step;
  logic [BcdW-1:0]     bcd_q, bcd_d, bcd_adj, bcd_step;
  logic [StepW-1:0]    step_q, step_d;
  logic                neg_next_q, neg_next_d;
  logic                neg_q, neg_d;
  logic [7*DIGITS-1:0] seg_q, seg_d, seg_new;
  logic                valid_q, valid_d;
  logic [BcdW+RW-1:0]  dd_shift;

  // One double-dabble step: add 3 to every nibble >= 5, then shift left.
  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (bcd_q[4*k+:4] >= 4'd5) bcd_adj[4*k+:4] = bcd_q[4*k+:4] + 4'd3;
    end
    dd_shift = {bcd_adj, bin_q} << 1;
    bcd_step = dd_shift[RW+:BcdW];
    bin_step = dd_shift[RW-1:0];
  end

  // Segment image of the BCD value produced by the final step.
  always_comb begin
    logic [3:0] digit;
`ifdef CALC_LEADING_ZERO_BLANK_EN
    logic higher_nz;
    higher_nz = 1'b0;
`endif
    seg_new = '0;
    digit   = '0;
    for (int k = int'(DIGITS) - 1; k >= 0; k--) begin
      digit = bcd_step[4*k+:4];
`ifdef CALC_LEADING_ZERO_BLANK_EN
      if (k != 0 && !higher_nz && digit == 4'd0) seg_new[7*k+:7] = 7'b0000000;
      else                                       seg_new[7*k+:7] = seg7(digit);
      higher_nz = higher_nz | (digit != 4'd0);
`else
      seg_new[7*k+:7] = seg7(digit);
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    step_d     = step_q;
    neg_next_d = neg_next_q;
    neg_d      = neg_q;
    seg_d      = seg_q;
    valid_d    = 1'b0;
    case (state_q)
      StCapA: begin
        if (press_evt) begin
          a_d     = x;
          state_d = StCapB;
        end
      end
      StCapB: begin
        if (press_evt) begin
          if (op_sub) begin
            bin_d      = (a_q >= x) ? RW'(a_q - x) : RW'(x - a_q);
            neg_next_d = (a_q < x);
          end else begin
            bin_d      = RW'(a_q) + RW'(x);
            neg_next_d = 1'b0;
          end
          bcd_d   = '0;
          step_d  = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        // Presses in this state are dropped on purpose.
        bin_d  = bin_step;
        bcd_d  = bcd_step;
        step_d = step_q + 1'b1;
        if (step_q == StepW'(RW - 1)) begin
          seg_d   = seg_new;
          neg_d   = neg_next_q;
          valid_d = 1'b1;
          state_d = StShow;
        end
      end
      StShow: begin
        if (press_evt) begin
          a_d     = x;
          state_d = StCapB;
        end
      end
      default: state_d = StCapA;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StCapA;
      a_q        <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      step_q     <= '0;
      neg_next_q <= 1'b0;
      neg_q      <= 1'b0;
      seg_q      <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      step_q     <= step_d;
      neg_next_q <= neg_next_d;
      neg_q      <= neg_d;
      seg_q      <= seg_d;
      valid_q    <= valid_d;
    end
  end

  assign seg          = seg_q;
  assign neg          = neg_q;
  assign busy         = (state_q == StConvert);
  assign result_valid = valid_q;

endmodule

// File: tb/tb_calc_core.sv
module tb_calc_core;

  localparam int W   = 4;
  localparam int DG  = 2;
  localparam int DEB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (DEBOUNCE_CYCLES = 4)
  logic          rst, button, op_sub;
  logic [W-1:0]  x;
  logic [7*DG-1:0] seg;
  logic          neg, busy, result_valid;

  // Fast-debounce instance, used to land a press inside a conversion
  logic          rst_f, button_f, op_sub_f;
  logic [W-1:0]  x_f;
  logic [7*DG-1:0] seg_f;
  logic          neg_f, busy_f, valid_f;

  calc_core #(.WIDTH(W), .DIGITS(DG), .DEBOUNCE_CYCLES(DEB)) u_dut (
    .clk(clk), .rst(rst), .button(button), .x(x), .op_sub(op_sub),
    .seg(seg), .neg(neg), .busy(busy), .result_valid(result_valid)
  );

  calc_core #(.WIDTH(W), .DIGITS(DG), .DEBOUNCE_CYCLES(1)) u_fast (
    .clk(clk), .rst(rst_f), .button(button_f), .x(x_f), .op_sub(op_sub_f),
    .seg(seg_f), .neg(neg_f), .busy(busy_f), .result_valid(valid_f)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] seg_tab [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                               7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  // Reference: decimal digits of r rendered through the segment table.
  function automatic logic [7*DG-1:0] model_seg(input int r);
    logic [7*DG-1:0] s;
    int v;
    int dgt [DG];
`ifdef CALC_LEADING_ZERO_BLANK_EN
    bit lead;
    lead = 1'b1;
`endif
    s = '0;
    v = r;
    for (int k = 0; k < DG; k++) begin
      dgt[k] = v % 10;
      v = v / 10;
    end
    for (int k = DG - 1; k >= 0; k--) begin
`ifdef CALC_LEADING_ZERO_BLANK_EN
      if (k > 0 && lead && dgt[k] == 0) s[7*k+:7] = 7'b0000000;
      else begin
        s[7*k+:7] = seg_tab[dgt[k]];
        lead = 1'b0;
      end
`else
      s[7*k+:7] = seg_tab[dgt[k]];
`endif
    end
    return s;
  endfunction

  // Observations gathered during one press of the main instance
  int ob_cyc, ob_busy, ob_first_busy, ob_last_busy, ob_valid, ob_valid_idx;
  logic [7*DG-1:0] ob_seg;
  logic ob_neg;

  task automatic clear_obs();
    ob_cyc = 0; ob_busy = 0; ob_first_busy = -1; ob_last_busy = -1;
    ob_valid = 0; ob_valid_idx = -1; ob_seg = '0; ob_neg = 1'b0;
  endtask

  task automatic sample();
    ob_cyc++;
    if (busy) begin
      if (ob_first_busy < 0) ob_first_busy = ob_cyc;
      ob_last_busy = ob_cyc;
      ob_busy++;
    end
    if (result_valid) begin
      ob_valid++;
      ob_valid_idx = ob_cyc;
      ob_seg = seg;
      ob_neg = neg;
    end
  endtask

  // Press the button with x=xv for 'hold' cycles, then release with x scrambled.
  task automatic press(input logic [W-1:0] xv, input logic sub, input int hold);
    clear_obs();
    x = xv; op_sub = sub; button = 1'b1;
    repeat (hold) begin @(negedge clk); sample(); end
    button = 1'b0; x = W'($urandom); op_sub = 1'($urandom);
    repeat (16) begin @(negedge clk); sample(); end
  endtask

  task automatic do_calc(input int a, input int b, input logic sub, input string name);
    int r;
    logic en;
    logic [7*DG-1:0] es;
    press(W'(a), 1'($urandom), 12);
    checks++;
    if (ob_busy !== 0 || ob_valid !== 0) begin
      errors++;
      $display("FAIL %s capture_a: busy_cycles=%0d valid=%0d required 0/0", name, ob_busy,
               ob_valid);
    end
    press(W'(b), sub, 12);
    r  = sub ? ((a >= b) ? a - b : b - a) : a + b;
    en = sub && (a < b);
    es = model_seg(r);
    checks++;
    if (ob_valid !== 1) begin
      errors++;
      $display("FAIL %s valid_count: got %0d required 1", name, ob_valid);
    end
    checks++;
    if (ob_busy !== W + 1 || ob_last_busy - ob_first_busy + 1 !== W + 1 ||
        ob_valid_idx !== ob_last_busy + 1) begin
      errors++;
      $display("FAIL %s latency: busy=%0d span=%0d..%0d valid_at=%0d required busy=%0d",
               name, ob_busy, ob_first_busy, ob_last_busy, ob_valid_idx, W + 1);
    end
    checks++;
    if (ob_seg !== es) begin
      errors++;
      $display("FAIL %s seg: got %b required %b (result %0d)", name, ob_seg, es, r);
    end
    checks++;
    if (ob_neg !== en) begin
      errors++;
      $display("FAIL %s neg: got %b required %b", name, ob_neg, en);
    end
    checks++;
    if (seg !== es || neg !== en) begin
      errors++;
      $display("FAIL %s hold: seg=%b neg=%b required %b %b", name, seg, neg, es, en);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rst_f = 1'b1;
    button = 1'b0; x = '0; op_sub = 1'b0;
    button_f = 1'b0; x_f = '0; op_sub_f = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (seg !== '0 || neg !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset: seg=%b neg=%b busy=%b valid=%b required all 0", seg, neg, busy,
               result_valid);
    end
    checks++;
    if (seg_f !== '0 || busy_f !== 1'b0 || valid_f !== 1'b0) begin
      errors++;
      $display("FAIL reset_fast: seg=%b busy=%b valid=%b required all 0", seg_f, busy_f,
               valid_f);
    end
    rst = 1'b0; rst_f = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_add();
    do_calc(7, 8, 1'b0, "add_7_8");
    checks++;
    if (seg !== {7'b0000110, 7'b1101101}) begin
      errors++;
      $display("FAIL add_15_pattern: got %b required %b", seg, {7'b0000110, 7'b1101101});
    end
  endtask

  task automatic test_sub();
    do_calc(3, 9, 1'b1, "sub_3_9");
    do_calc(9, 3, 1'b1, "sub_9_3");
    do_calc(5, 5, 1'b1, "sub_equal");
  endtask

  task automatic test_max_chain();
    do_calc(15, 15, 1'b0, "max_add");
    do_calc(2, 2, 1'b0, "chain_2_2");
  endtask

  task automatic test_debounce();
    // Three-cycle glitch must not capture anything.
    clear_obs();
    x = 4'd5; button = 1'b1;
    repeat (3) begin @(negedge clk); sample(); end
    button = 1'b0;
    repeat (12) begin @(negedge clk); sample(); end
    do_calc(1, 2, 1'b0, "after_glitch");
    // A long hold is a single press, so it only captures A.
    press(4'd6, 1'b0, 100);
    checks++;
    if (ob_busy !== 0 || ob_valid !== 0) begin
      errors++;
      $display("FAIL held_press: busy_cycles=%0d valid=%0d required 0/0", ob_busy, ob_valid);
    end
    press(4'd3, 1'b0, 12);
    checks++;
    if (ob_valid !== 1 || ob_seg !== model_seg(9)) begin
      errors++;
      $display("FAIL held_then_b: valid=%0d seg=%b required 1 %b", ob_valid, ob_seg,
               model_seg(9));
    end
  endtask

  int f_valid, f_busy_in_p3;
  logic [7*DG-1:0] f_seg;

  task automatic sample_f(input bit p3);
    if (valid_f) begin f_valid++; f_seg = seg_f; end
    if (p3 && busy_f) f_busy_in_p3++;
  endtask

  task automatic fast_pulse(input logic [W-1:0] xv, input logic sub, input bit p3);
    x_f = xv; op_sub_f = sub; button_f = 1'b1;
    repeat (2) begin @(negedge clk); sample_f(p3); end
    button_f = 1'b0;
    repeat (2) begin @(negedge clk); sample_f(p3); end
  endtask

  task automatic test_press_during_convert();
    f_valid = 0; f_busy_in_p3 = 0; f_seg = '0;
    fast_pulse(4'd4, 1'b0, 1'b0);
    fast_pulse(4'd5, 1'b0, 1'b0);
    fast_pulse(4'd9, 1'b1, 1'b1);
    repeat (12) begin @(negedge clk); sample_f(1'b0); end
    checks++;
    if (f_busy_in_p3 == 0) begin
      errors++;
      $display("FAIL convert_overlap: busy seen %0d times during third press, required >0",
               f_busy_in_p3);
    end
    checks++;
    if (f_valid !== 1 || f_seg !== model_seg(9)) begin
      errors++;
      $display("FAIL press_in_convert: valid=%0d seg=%b required 1 %b", f_valid, f_seg,
               model_seg(9));
    end
    fast_pulse(4'd1, 1'b0, 1'b0);
    fast_pulse(4'd2, 1'b0, 1'b0);
    repeat (12) begin @(negedge clk); sample_f(1'b0); end
    checks++;
    if (f_valid !== 2 || f_seg !== model_seg(3)) begin
      errors++;
      $display("FAIL after_dropped_press: valid=%0d seg=%b required 2 %b", f_valid, f_seg,
               model_seg(3));
    end
  endtask

  task automatic test_reset_mid_convert();
    int nb;
    bit hit;
    press(4'd6, 1'b0, 12);
    nb = 0; hit = 1'b0;
    x = 4'd7; op_sub = 1'b0; button = 1'b1;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (nb == 2) begin
        rst = 1'b1; button = 1'b0; hit = 1'b1;
      end
    end
    button = 1'b0;
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL rst_mid_convert: busy not seen twice within 40 cycles, got %0d", nb);
    end
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (seg !== '0 || neg !== 1'b0 || busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_convert_state: seg=%b neg=%b busy=%b valid=%b required all 0",
               seg, neg, busy, result_valid);
    end
    clear_obs();
    repeat (20) begin @(negedge clk); sample(); end
    checks++;
    if (ob_valid !== 0 || seg !== '0) begin
      errors++;
      $display("FAIL rst_no_partial: valid=%0d seg=%b required 0 and 0", ob_valid, seg);
    end
    do_calc(2, 3, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_calc(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)), 1'($urandom),
              "random");
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_max_chain();
    test_debounce();
    test_press_during_convert();
    test_reset_mid_convert();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
